// File: rtl/text_term_ctrl.sv
// Keyboard-side terminal controller: tracks a row/column cursor and writes characters into the VGA character RAM.
// Optional cursor blink is compiled in with `define CURSOR_BLINK_EN.
module text_term_ctrl #(
    parameter int COLS      = 71,
    parameter int ROWS      = 30,
    parameter int BLINK_DIV = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_ascii,
    output logic        key_ready,
    output logic        we,
    output logic [11:0] waddr,
    output logic [7:0]  wdata,
    output logic [11:0] cur
);
    localparam int              CW        = $clog2(COLS);
    localparam int              RW        = $clog2(ROWS);
    localparam logic [11:0]     LAST_ADDR = 12'(COLS * ROWS - 1);
    localparam logic [CW-1:0]   COL_MAX   = CW'(COLS - 1);
    localparam logic [RW-1:0]   ROW_MAX   = RW'(ROWS - 1);
    localparam logic [7:0]      SPACE     = 8'h20;

    if (BLINK_DIV < 1 || COLS * ROWS > 4096) begin : g_bad_params
        $error("text_term_ctrl: BLINK_DIV must be >= 1 and the screen must fit a 12-bit address");
    end

    typedef enum logic {S_CLEAR, S_IDLE} state_e;
    typedef enum logic [2:0] {K_IGNORE, K_PRINT, K_BS, K_ENTER, K_FF} key_e;

    function automatic logic [11:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return 12'(r) * 12'(COLS) + 12'(c);
    endfunction

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [11:0]   clr_cnt_q, clr_cnt_d;
    logic          we_q, we_d;
    logic [11:0]   waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [11:0]   cur_q, cur_d;
    logic          key_ready_q, key_ready_d;

    key_e          key_kind;
    logic          accept;
    logic [11:0]   cur_addr, next_addr;

    // key_ready_q is only ever set while IDLE, so it alone qualifies acceptance.
    assign accept    = key_valid && key_ready_q;
    assign cur_addr  = cell_addr(row_q, col_q);
    assign next_addr = cell_addr(row_d, col_d);

    always_comb begin
        key_kind = K_IGNORE;
        if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) key_kind = K_PRINT;
        else if (key_ascii == 8'h08)                   key_kind = K_BS;
        else if (key_ascii == 8'h0D)                   key_kind = K_ENTER;
        else if (key_ascii == 8'h0C)                   key_kind = K_FF;
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= S_CLEAR;
            row_q       <= '0;
            col_q       <= '0;
            clr_cnt_q   <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= SPACE;
            cur_q       <= '0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            clr_cnt_q   <= clr_cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cur_q       <= cur_d;
            key_ready_q <= key_ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 12'd1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                    row_d     = '0;
                    col_d     = '0;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    unique case (key_kind)
                        K_PRINT: begin
                            if (cur_addr == LAST_ADDR) begin
                                state_d = S_CLEAR;
                            end else if (col_q == COL_MAX) begin
                                col_d = '0;
                                row_d = row_q + RW'(1);
                            end else begin
                                col_d = col_q + CW'(1);
                            end
                        end
                        K_BS: begin
                            if (cur_addr != 12'd0) begin
                                if (col_q == '0) begin
                                    col_d = COL_MAX;
                                    row_d = row_q - RW'(1);
                                end else begin
                                    col_d = col_q - CW'(1);
                                end
                            end
                        end
                        K_ENTER: begin
                            if (row_q == ROW_MAX) begin
                                state_d = S_CLEAR;
                            end else begin
                                col_d = '0;
                                row_d = row_q + RW'(1);
                            end
                        end
                        K_FF:     state_d = S_CLEAR;
                        default:  ;
                    endcase
                    if (state_d == S_CLEAR) begin
                        row_d     = '0;
                        col_d     = '0;
                        clr_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

`ifdef CURSOR_BLINK_EN
    localparam int           BW         = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Typing restarts the blink in the visible phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_on_d  = blink_on_q;
        if (accept) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end
`endif

    // Output logic: all ports are registered, this computes their next values.
    always_comb begin
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        key_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
`ifdef CURSOR_BLINK_EN
        cur_d       = (state_d == S_CLEAR) ? 12'd0 : (blink_on_d ? next_addr : 12'hFFF);
`else
        cur_d       = (state_d == S_CLEAR) ? 12'd0 : next_addr;
`endif
        if (state_q == S_CLEAR) begin
            we_d    = 1'b1;
            waddr_d = clr_cnt_q;
            wdata_d = SPACE;
        end else if (accept && key_kind == K_PRINT) begin
            we_d    = 1'b1;
            waddr_d = cur_addr;
            wdata_d = key_ascii;
        end else if (accept && key_kind == K_BS && cur_addr != 12'd0) begin
            we_d    = 1'b1;
            waddr_d = cur_addr - 12'd1;
            wdata_d = SPACE;
        end
    end

    assign key_ready = key_ready_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign cur       = cur_q;
endmodule

// File: doc/text_term_ctrl.md
Name: text_term_ctrl

Overview:
- Keyboard-side terminal controller that sits directly upstream of the VGA text generator.
- Accepts decoded ASCII key events, maintains a row/column cursor, and issues single-cycle writes into the character RAM.
- Drives the character RAM write port (we/waddr/wdata) and the cursor address consumed by the display stage.
- Performs a full-screen clear to spaces after reset, on form feed, and on screen overflow.

Parameters:
- COLS, 71, characters per row (640 px / 9 px cell).
- ROWS, 30, character rows (480 px / 16 px cell).
- BLINK_DIV, 12500000, clk cycles per cursor blink half-period (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  key event strobe; accepted only when key_ready=1.
- key_ascii  input  8  ASCII code of the key event.
- key_ready  output  1  controller can accept a key this cycle.
- we  output  1  character RAM write enable, one-cycle pulses.
- waddr  output  12  character RAM write address, equal to row*COLS+col.
- wdata  output  8  character RAM write data.
- cur  output  12  cursor cell address for the display stage.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All outputs are registered.
- Reset values: we=0, waddr=0, wdata=8'h20, cur=0, key_ready=0, row=0, col=0, state=CLEAR, clear counter=0.
- Address arithmetic: 12-bit, addr=row*COLS+col. The last cell is COLS*ROWS-1 (2129). Row and column counters never exceed ROWS-1 / COLS-1.
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle: we=1, wdata=8'h20, waddr=clear counter; counter then increments.
  - key_ready=0; cur=0.
  - After writing address COLS*ROWS-1: row=col=0, go to IDLE.
  - The first write occurs in the cycle after reset deasserts. The clear lasts exactly COLS*ROWS cycles.
- IDLE: key_ready=1. A key is accepted in cycle N when key_valid & key_ready. Effects appear in cycle N+1; we pulses for one cycle only.
- Printable key (8'h20..8'h7E):
  - Write: we=1, waddr=old cursor address, wdata=key_ascii.
  - Cursor advances: col+1. At col=COLS-1: col=0, row+1.
  - If the written cell was the last cell (2129): enter CLEAR in cycle N+1, after the write.
- Backspace (8'h08):
  - Cursor retreats: col-1. At col=0: col=COLS-1, row-1.
  - Write: we=1, waddr=new cursor address, wdata=8'h20.
  - At address 0: no write, no move.
- Enter (8'h0D): col=0, row+1, no write. At row=ROWS-1: enter CLEAR.
- Form feed (8'h0C): enter CLEAR.
- All other codes: ignored, no write, cursor unchanged.
- Keys presented while key_ready=0 are dropped, not queued.
- cur follows the cursor address with 1-cycle latency from acceptance.
- key_ready deasserts in the same cycle that CLEAR is entered.
- Reset asserted mid-CLEAR or mid-write: aborts the operation, reloads reset values, and restarts a full CLEAR.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - A counter toggles a blink phase every BLINK_DIV cycles.
  - cur=cursor address in the on phase, 12'hFFF (out of range, so no cursor is drawn) in the off phase.
  - Phase and counter reset to on/0 on reset and on every accepted key.
  - During CLEAR, cur=0 regardless of phase.
- Not defined: no blink logic; cur is always the cursor address (0 during CLEAR).

Test Plan:
- Reset 2 cycles, release -> 2130 consecutive we pulses, waddr 0..2129, wdata=8'h20, key_ready=0; then key_ready=1, cur=0.
- Key 8'h41 at cursor 0 -> next cycle we=1, waddr=0, wdata=8'h41, cur=1; the following cycle we=0.
- Cursor at col 70 row 0, key 8'h42 -> waddr=70, cur=71; then Enter -> cur=142, no we; then Backspace -> cur=141, we=1, waddr=141, wdata=8'h20.
- Backspace at cur=0 -> no we, cur stays 0. Key 8'h07 -> ignored, no write, cursor unchanged.
- Cursor at 2129, key 8'h5A -> write at 2129, then full 2130-cycle CLEAR; key_valid pulses during CLEAR are dropped (no writes besides clear); ends with cur=0.
- Reset asserted mid-CLEAR at address 1000 -> waddr restarts at 0 one cycle after release. With CURSOR_BLINK_EN and BLINK_DIV=4: cur alternates cursor address / 12'hFFF every 4 cycles; an accepted key restores the on phase.
